// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core load/store path (port 0) vs debug/loader (port 1).
// Optional port-1 bus lock is built when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [31:0]   p0_addr,
  input  logic [3:0]    p0_be,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [31:0]   p1_addr,
  input  logic [3:0]    p1_be,
  input  logic [31:0]   p1_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          p1_lock,
`endif
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,
  output logic          p1_err,
  output logic          core_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  logic        prio;
  logic        prio_eff;
  logic        lock_hold;
  logic        any_gnt;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] sel_word;
  logic        in_range;
  logic        vld_p1;
  logic        owner_p1;
  logic        err_p1;
  logic        load_p1;
  logic        rsp_live;
  logic [31:0] rsp_data;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^{p0_addr[1:0], p1_addr[1:0]};

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (p1_gnt && p1_lock) state_nxt = LOCKED;
      LOCKED:  if (!p1_lock)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The cycle the lock drops is arbitrated as IDLE with the core favoured.
  always_comb begin
    lock_hold = (state == LOCKED) && p1_lock;
    prio_eff  = (state == LOCKED) ? 1'b0 : prio;
  end
`else
  assign lock_hold = 1'b0;
  assign prio_eff  = prio;
`endif

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      if (lock_hold) begin
        p1_gnt = p1_req;
      end else if (p0_req && p1_req) begin
        p0_gnt = ~prio_eff;
        p1_gnt = prio_eff;
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  assign any_gnt    = p0_gnt | p1_gnt;
  assign core_stall = p0_req & ~p0_gnt;

  always_ff @(posedge clk) begin
    if (rst)                       prio <= 1'b0;
    else if (any_gnt && !lock_hold) prio <= p0_gnt;
  end

  always_comb begin
    sel_we    = p1_gnt ? p1_we    : p0_we;
    sel_be    = p1_gnt ? p1_be    : p0_be;
    sel_addr  = p1_gnt ? p1_addr  : p0_addr;
    sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
    sel_word  = {2'b00, sel_addr[31:2]};
    in_range  = sel_word < 32'(DEPTH_WORDS);
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (any_gnt) begin
      mem_en    = in_range;
      mem_we    = sel_we;
      mem_be    = sel_be;
      mem_addr  = sel_addr[AW+1:2];
      mem_wdata = sel_wdata;
    end
  end

  // Stage p1: response owner/type captured at grant, answered next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      owner_p1 <= 1'b0;
      err_p1   <= 1'b0;
      load_p1  <= 1'b0;
    end else begin
      vld_p1   <= any_gnt;
      owner_p1 <= p1_gnt;
      err_p1   <= ~in_range;
      load_p1  <= ~sel_we;
    end
  end

  // Gating with rst drops a response that falls due while reset is asserted.
  always_comb begin
    rsp_live  = vld_p1 & ~rst;
    rsp_data  = (rsp_live && load_p1 && !err_p1) ? mem_rdata : 32'h0;
    p0_rvalid = rsp_live & ~owner_p1;
    p1_rvalid = rsp_live &  owner_p1;
    p0_err    = rsp_live & ~owner_p1 & err_p1;
    p1_err    = rsp_live &  owner_p1 & err_p1;
    p0_rdata  = owner_p1 ? 32'h0 : rsp_data;
    p1_rdata  = owner_p1 ? rsp_data : 32'h0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then randomized traffic
// against a rule-level reference model with a shadow memory.
module tb_dmem_arbiter;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic clk = 1'b0;
  logic rst;
  logic p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [3:0]  p0_be, p1_be;
  logic p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic core_stall, mem_en, mem_we;
  logic [3:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem    [DEPTH];
  logic [31:0] shadow [DEPTH];

  int passed = 0;
  int total  = 0;
  bit m_prio, m_locked, pv, pown, perr;
  logic [31:0] pdata;
  bit eg0, eg1, last_stall;
  int stall_cnt;

  dmem_arbiter #(.DEPTH_WORDS(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_be(p0_be), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_be(p1_be), .p1_wdata(p1_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .p1_lock(p1_lock),
`endif
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .core_stall(core_stall), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with registered read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, want);
  endtask

  // Checks all outputs for the current cycle and advances the model one cycle.
  task automatic eval();
    bit lk, hold, pr, g0, g1, we, inr, live;
    logic [3:0] be;
    logic [31:0] addr, wd, word;
    #3;
`ifdef DMEM_ARB_LOCK_EN
    lk = p1_lock;
`else
    lk = 1'b0;
`endif
    hold = m_locked && lk;
    pr   = m_locked ? 1'b0 : m_prio;
    g0 = 1'b0; g1 = 1'b0;
    if (!rst) begin
      if (hold) g1 = p1_req;
      else if (p0_req && p1_req) begin g1 = pr; g0 = !pr; end
      else begin g0 = p0_req; g1 = p1_req; end
    end
    live = pv && !rst;
    chk("p0_gnt", 32'(p0_gnt), 32'(g0));
    chk("p1_gnt", 32'(p1_gnt), 32'(g1));
    chk("core_stall", 32'(core_stall), 32'(p0_req && !g0));
    chk("p0_rvalid", 32'(p0_rvalid), 32'(live && !pown));
    chk("p1_rvalid", 32'(p1_rvalid), 32'(live && pown));
    chk("p0_err", 32'(p0_err), 32'(live && !pown && perr));
    chk("p1_err", 32'(p1_err), 32'(live && pown && perr));
    chk("p0_rdata", p0_rdata, (live && !pown) ? pdata : 32'h0);
    chk("p1_rdata", p1_rdata, (live && pown) ? pdata : 32'h0);
    we = g1 ? p1_we : p0_we;
    be = g1 ? p1_be : p0_be;
    addr = g1 ? p1_addr : p0_addr;
    wd = g1 ? p1_wdata : p0_wdata;
    word = addr >> 2;
    inr = word < DEPTH;
    if (g0 || g1) begin
      chk("mem_en", 32'(mem_en), 32'(inr));
      chk("mem_we", 32'(mem_we), 32'(we));
      chk("mem_be", 32'(mem_be), 32'(be));
      chk("mem_addr", 32'(mem_addr), word % DEPTH);
      chk("mem_wdata", mem_wdata, wd);
    end else begin
      chk("idle_mem", {mem_en, mem_we, mem_be, 26'(mem_addr)}, 32'h0);
      chk("idle_wdata", mem_wdata, 32'h0);
    end
    last_stall = core_stall;
    eg0 = g0; eg1 = g1;
    pv = g0 || g1;
    pown = g1;
    perr = !inr;
    pdata = (pv && !we && inr) ? shadow[word] : 32'h0;
    if (pv && we && inr)
      for (int b = 0; b < 4; b++)
        if (be[b]) shadow[word][b*8 +: 8] = wd[b*8 +: 8];
    if (rst) m_prio = 1'b0;
    else if (pv && !hold) m_prio = g0;
    if (rst) m_locked = 1'b0;
    else if (m_locked && !lk) m_locked = 1'b0;
    else if (!m_locked && g1 && lk) m_locked = 1'b1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    eval();
    adv();
  endtask

  task automatic rnd_fields(output logic we, output logic [3:0] be,
                            output logic [31:0] addr, output logic [31:0] wd);
    we   = 1'($urandom_range(0, 1));
    be   = 4'($urandom_range(1, 15));
    addr = (32'($urandom_range(0, DEPTH + 63)) << 2) | 32'($urandom_range(0, 3));
    wd   = $urandom;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = 32'h5A00_0000 ^ i;
      shadow[i] = 32'h5A00_0000 ^ i;
    end
    m_prio = 0; m_locked = 0; pv = 0; pown = 0; perr = 0; pdata = 0;
    rst = 1'b1; p1_lock = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_be = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_be = 0; p1_wdata = 0;
    adv();
    tick();
    p0_req = 1; p1_req = 1;
    tick();
    rst = 1'b0; p1_req = 0;

    // Single port store then load.
    p0_we = 1; p0_addr = 32'h10; p0_be = 4'hF; p0_wdata = 32'hDEADBEEF;
    eval();
    chk("st_mem_addr", 32'(mem_addr), 32'd4);
    adv();
    p0_we = 0;
    eval();
    chk("ld_mem_addr", 32'(mem_addr), 32'd4);
    adv();
    p0_req = 0;
    eval();
    chk("ld_rdata", p0_rdata, 32'hDEADBEEF);
    adv();

    // Contention right after reset: core first.
    rst = 1; tick(); rst = 0;
    p0_req = 1; p0_we = 0; p0_addr = 32'h20;
    p1_req = 1; p1_we = 0; p1_addr = 32'h40;
    eval();
    chk("cont_p0_first", 32'(p0_gnt), 32'd1);
    adv();
    p0_req = 0;
    eval();
    chk("cont_p1_second", 32'(p1_gnt), 32'd1);
    adv();
    p1_req = 0;
    tick();

    // Sustained contention.
    stall_cnt = 0;
    p0_req = 1; p1_req = 1;
    for (int c = 0; c < 8; c++) begin
      rnd_fields(p0_we, p0_be, p0_addr, p0_wdata);
      rnd_fields(p1_we, p1_be, p1_addr, p1_wdata);
      eval();
      stall_cnt += int'(last_stall);
      adv();
    end
    chk("stall_count", 32'(stall_cnt), 32'd4);

    // Out-of-range load from port 1.
    p0_req = 0; p1_we = 0; p1_addr = 32'h1000;
    eval();
    chk("oor_mem_en", 32'(mem_en), 32'd0);
    adv();
    p1_req = 0;
    eval();
    chk("oor_err", 32'(p1_err), 32'd1);
    adv();

    // Reset while a load response is pending.
    p0_req = 1; p0_we = 0; p0_addr = 32'h30;
    tick();
    p0_req = 0; rst = 1;
    eval();
    chk("rst_drop_rvalid", 32'(p0_rvalid), 32'd0);
    adv();
    tick();
    rst = 0; p0_req = 1; p1_req = 1; p1_addr = 32'h44;
    eval();
    chk("rst_prio_p0", 32'(p0_gnt), 32'd1);
    adv();
    p0_req = 0; tick();
    p1_req = 0; tick();

`ifdef DMEM_ARB_LOCK_EN
    // Port 1 lock holds off the core for three grants.
    p0_req = 1; tick();
    p1_req = 1; p1_lock = 1;
    for (int c = 0; c < 3; c++) begin
      eval();
      chk("lock_p1_gnt", 32'(p1_gnt), 32'd1);
      chk("lock_stall", 32'(core_stall), 32'd1);
      adv();
    end
    p1_lock = 0;
    eval();
    chk("unlock_p0_gnt", 32'(p0_gnt), 32'd1);
    adv();
    p0_req = 0; p1_req = 0; tick();
`endif

    // Randomized traffic; requests stay up until granted.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      p1_lock = ($urandom_range(0, 2) == 0);
      if (!p0_req || eg0) begin
        p0_req = ($urandom_range(0, 2) != 0);
        rnd_fields(p0_we, p0_be, p0_addr, p0_wdata);
      end else if ($urandom_range(0, 3) == 0) begin
        rnd_fields(p0_we, p0_be, p0_addr, p0_wdata);
      end
      if (!p1_req || eg1) begin
        p1_req = ($urandom_range(0, 2) != 0);
        rnd_fields(p1_we, p1_be, p1_addr, p1_wdata);
      end else if ($urandom_range(0, 3) == 0) begin
        rnd_fields(p1_we, p1_be, p1_addr, p1_wdata);
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
